// File: rtl/result_drain_if.sv
// Output beat stream of result_drain: 512-bit valid/ready beats with an
// end-of-drain marker on the high beat of the final line.
interface result_drain_if;
    logic         m_valid;
    logic         m_ready;
    logic [511:0] m_data;
    logic         m_last;

    modport master (output m_valid, output m_data, output m_last, input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_last, output m_ready);
endinterface

// File: rtl/result_drain.sv
// Drains result RAM lines 0..end_address as two 512-bit beats per line, then
// pulses block_out_finish or page_finish. Optional stall counter: RESULT_DRAIN_STALL_CNT_EN.
module result_drain #(
    parameter int LINE_CREDITS = 2,
    parameter int CLEAR_CYCLES = 514
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [8:0]      end_address,
    input  logic            last_page,
    output logic            rd_en,
    output logic [8:0]      rd_address,
    input  logic [1023:0]   ram_data,
    result_drain_if.master  m_if,
    output logic            block_out_finish,
    output logic            page_finish,
    output logic            busy,
    output logic [31:0]     stall_cycles
);
    localparam int PW = (LINE_CREDITS > 2) ? 2 : 1;
    localparam int CW = $clog2(LINE_CREDITS + 1) + 1;
    localparam int KW = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FINISH, S_CLEAR} state_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(LINE_CREDITS - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t          r_state;
    logic            r_busy;
    logic            r_rd_en;
    logic [8:0]      r_rd_addr;
    logic [9:0]      r_rd_ptr;
    logic            r_cap_p1;
    logic [8:0]      r_end_addr;
    logic            r_last_page;
    logic [8:0]      r_out_line;
    logic            r_beat;
    logic [PW-1:0]   r_wrp;
    logic [PW-1:0]   r_rdp;
    logic [CW-1:0]   r_cnt;
    logic            r_blk_fin;
    logic            r_pg_fin;
    logic [KW-1:0]   r_clr_cnt;
    logic [1023:0]   r_fifo [LINE_CREDITS];

    logic            w_valid;
    logic            w_acc;
    logic            w_pop;
    logic            w_at_end;
    logic            w_issue;
    logic [CW-1:0]   w_occ;
    logic [1023:0]   w_head;

    assign w_head   = r_fifo[r_rdp];
    assign w_valid  = (r_state == S_DRAIN) && (r_cnt != '0);
    assign w_acc    = w_valid && m_if.m_ready;
    assign w_pop    = w_acc && r_beat;
    assign w_at_end = (r_out_line == r_end_addr);
    // A line popping this cycle frees its credit immediately, so reads stay back-to-back.
    assign w_occ    = r_cnt + CW'(r_rd_en) + CW'(r_cap_p1) - CW'(w_pop);
    assign w_issue  = (r_state == S_DRAIN) && (r_rd_ptr <= {1'b0, r_end_addr}) &&
                      (w_occ < CW'(LINE_CREDITS));

    assign m_if.m_valid     = w_valid;
    assign m_if.m_data      = !w_valid ? '0 : (r_beat ? w_head[1023:512] : w_head[511:0]);
    assign m_if.m_last      = w_valid && r_beat && w_at_end;
    assign rd_en            = r_rd_en;
    assign rd_address       = r_rd_addr;
    assign block_out_finish = r_blk_fin;
    assign page_finish      = r_pg_fin;
    assign busy             = r_busy;

    // Stage p1: capture RAM output one cycle after the read was issued
    always_ff @(posedge clk) begin
        if (r_cap_p1) r_fifo[r_wrp] <= ram_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_ptr    <= '0;
            r_cap_p1    <= 1'b0;
            r_end_addr  <= '0;
            r_last_page <= 1'b0;
            r_out_line  <= '0;
            r_beat      <= 1'b0;
            r_wrp       <= '0;
            r_rdp       <= '0;
            r_cnt       <= '0;
            r_blk_fin   <= 1'b0;
            r_pg_fin    <= 1'b0;
            r_clr_cnt   <= '0;
        end else begin
            r_rd_en   <= 1'b0;
            r_cap_p1  <= r_rd_en;
            r_blk_fin <= 1'b0;
            r_pg_fin  <= 1'b0;
            if (r_cap_p1) r_wrp <= ptr_inc(r_wrp);
            if (w_pop) begin
                r_rdp      <= ptr_inc(r_rdp);
                r_out_line <= r_out_line + 9'd1;
            end
            if (w_acc) r_beat <= ~r_beat;
            r_cnt <= r_cnt + CW'(r_cap_p1) - CW'(w_pop);

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_DRAIN;
                        r_busy      <= 1'b1;
                        r_end_addr  <= end_address;
                        r_last_page <= last_page;
                        r_rd_en     <= 1'b1;
                        r_rd_addr   <= '0;
                        r_rd_ptr    <= 10'd1;
                        r_out_line  <= '0;
                        r_beat      <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_issue) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_rd_ptr[8:0];
                        r_rd_ptr  <= r_rd_ptr + 10'd1;
                    end
                    if (w_pop && w_at_end) begin
                        r_state   <= S_FINISH;
                        r_pg_fin  <= r_last_page;
                        r_blk_fin <= !r_last_page;
                    end
                end
                S_FINISH: begin
                    r_clr_cnt <= '0;
                    if (r_last_page) begin
                        r_state <= S_CLEAR;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == KW'(CLEAR_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef RESULT_DRAIN_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_stall <= '0;
        end else if (w_valid && !m_if.m_ready) begin
            r_stall <= sat_inc(r_stall);
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: random line contents, several m_ready
// patterns, finish/clear timing, reset mid-drain and ignored starts.
module tb_result_drain;
    localparam int LINE_CREDITS = 2;
    localparam int CLEAR_CYCLES = 514;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [8:0]     end_address;
    logic           last_page;
    logic           rd_en;
    logic [8:0]     rd_address;
    logic [1023:0]  ram_data;
    logic           block_out_finish;
    logic           page_finish;
    logic           busy;
    logic [31:0]    stall_cycles;

    result_drain_if bus ();

    result_drain #(.LINE_CREDITS(LINE_CREDITS), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .end_address(end_address),
        .last_page(last_page), .rd_en(rd_en), .rd_address(rd_address),
        .ram_data(ram_data), .m_if(bus), .block_out_finish(block_out_finish),
        .page_finish(page_finish), .busy(busy), .stall_cycles(stall_cycles)
    );

    int checks = 0, errors = 0;
    int cyc = 0, exp_addr = 0, rd_issued = 0, popped = 0, drain_beats = 0;
    int stalls = 0, fin_blk = 0, fin_pg = 0, first_cyc = 0, last_cyc = 0;
    int rmode = 0, pidx = 0;
    bit pend_fin = 0, prev_stall = 0, cur_lp = 0;
    logic [511:0] prev_data;
    logic         prev_last;
    logic [31:0]  seed;
    logic [512:0] exp_q[$];
    logic [512:0] e;
    logic [1:0]   exp_f;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line contents derived from a per-drain seed and the line address
    function automatic logic [1023:0] mkline(input logic [31:0] s, input logic [8:0] a);
        logic [1023:0] v;
        for (int k = 0; k < 32; k++)
            v[32*k +: 32] = s ^ ((32'(a) * 32'd32 + 32'(k)) * 32'h9E3779B1);
        return v;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM model: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) ram_data <= mkline(seed, rd_address);
    end

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
            pidx++;
        end
    end

    // Monitor: address order, credits, stability, finish pulses, beat scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_fin   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            cyc++;
            if (rd_en) begin
                chk(rd_address == exp_addr[8:0] && exp_addr < 512, "rd_addr", rd_address, exp_addr);
                exp_addr++;
                rd_issued++;
                chk(rd_issued - popped <= LINE_CREDITS, "credits", rd_issued - popped, LINE_CREDITS);
            end
            if (prev_stall)
                chk(bus.m_valid && bus.m_data == prev_data && bus.m_last == prev_last,
                    "stable", bus.m_data, prev_data);
            if (pend_fin || block_out_finish || page_finish) begin
                exp_f = !pend_fin ? 2'b00 : (cur_lp ? 2'b10 : 2'b01);
                chk({page_finish, block_out_finish} == exp_f, "finish_pulse",
                    {page_finish, block_out_finish}, exp_f);
                if (block_out_finish) fin_blk++;
                if (page_finish) fin_pg++;
            end
            pend_fin = 1'b0;
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_beat", bus.m_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(bus.m_data == e[511:0], "beat_data", bus.m_data, e[511:0]);
                    chk(bus.m_last == e[512], "beat_last", bus.m_last, e[512]);
                end
                if (drain_beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                if (drain_beats % 2 == 1) popped++;
                drain_beats++;
                if (bus.m_last) pend_fin = 1'b1;
            end
            if (bus.m_valid && !bus.m_ready) stalls++;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    task automatic prep(input int ea, input bit lp, input int mode);
        logic [1023:0] ln;
        seed  = $urandom;
        cur_lp = lp;
        rmode = mode;
        for (int a = 0; a <= ea; a++) begin
            ln = mkline(seed, 9'(a));
            exp_q.push_back({1'b0, ln[511:0]});
            exp_q.push_back({a == ea, ln[1023:512]});
        end
        exp_addr = 0; rd_issued = 0; popped = 0; drain_beats = 0;
        stalls = 0; fin_blk = 0; fin_pg = 0;
    endtask

    // inj: 0 none, 1 extra start mid-drain, 2 extra start during clear
    task automatic run_drain(input int ea, input bit lp, input int mode, input int inj);
        int nbeats = 2 * (ea + 1);
        int clr = 0;
        bit seen = 0, done = 0, injected = 0;
        int exp_stall;
        prep(ea, lp, mode);
        @(negedge clk); #1;
        start = 1'b1; end_address = 9'(ea); last_page = lp;
        @(posedge clk); #1;
        start = 1'b0; end_address = 9'($urandom); last_page = 1'($urandom);
        chk(busy && rd_en && rd_address == 9'd0, "start_resp", {busy, rd_en, rd_address}, 11'h600);
        @(posedge clk); #1;
        chk(!bus.m_valid, "valid_early", bus.m_valid, 0);
        @(posedge clk); #1;
        chk(bus.m_valid, "first_valid", bus.m_valid, 1);
        for (int c = 0; c < nbeats * 4 + CLEAR_CYCLES + 100; c++) begin
            @(negedge clk); #1;
            if (seen && busy) clr++;
            if (fin_pg > 0) seen = 1'b1;
            start = 1'b0;
            if (!injected && ((inj == 1 && drain_beats == 2) || (inj == 2 && clr == 100))) begin
                start = 1'b1;
                end_address = (inj == 1) ? 9'd9 : 9'd5;
                injected = 1'b1;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk(done, "drain_timeout", done, 1);
        chk(drain_beats == nbeats, "beat_count", drain_beats, nbeats);
        chk(rd_issued == ea + 1, "read_count", rd_issued, ea + 1);
        chk(exp_q.size() == 0, "missing_beats", exp_q.size(), 0);
        chk(fin_blk == int'(!lp) && fin_pg == int'(lp), "finish_count", {fin_pg, fin_blk}, {lp, !lp});
        chk(clr == (lp ? CLEAR_CYCLES : 0), "clear_len", clr, lp ? CLEAR_CYCLES : 0);
        if (mode == 0)
            chk(last_cyc - first_cyc == nbeats - 1, "back_to_back", last_cyc - first_cyc, nbeats - 1);
`ifdef RESULT_DRAIN_STALL_CNT_EN
        exp_stall = stalls;
`else
        exp_stall = 0;
`endif
        chk(stall_cycles == 32'(exp_stall), "stall_cycles", stall_cycles, exp_stall);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; end_address = '0; last_page = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({rd_en, bus.m_valid, bus.m_last, block_out_finish, page_finish, busy} == 6'd0,
            "reset_ctrl", {rd_en, bus.m_valid, bus.m_last, block_out_finish, page_finish, busy}, 0);
        chk(rd_address == 9'd0 && stall_cycles == 32'd0, "reset_cnt", {rd_address, stall_cycles}, 0);
        chk(bus.m_data == '0, "reset_data", bus.m_data, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_drain(3, 1'b0, 0, 0);
        run_drain(7, 1'b0, 1, 0);
        for (int i = 0; i < 3; i++) run_drain($urandom_range(1, 12), 1'b0, 2, 0);
        run_drain(0, 1'b1, 0, 2);
        run_drain(511, 1'b0, 0, 0);

        // Reset in the middle of a drain
        prep(7, 1'b0, 0);
        @(negedge clk); #1;
        start = 1'b1; end_address = 9'd7; last_page = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 50 && drain_beats < 3; c++) begin
            @(negedge clk); #1;
        end
        chk(drain_beats >= 3, "mid_drain_beats", drain_beats, 3);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk({rd_en, bus.m_valid, bus.m_last, block_out_finish, page_finish, busy} == 6'd0,
            "async_reset_ctrl", {rd_en, bus.m_valid, bus.m_last, block_out_finish, page_finish, busy}, 0);
        chk(rd_address == 9'd0 && bus.m_data == '0 && stall_cycles == 32'd0, "async_reset_data",
            bus.m_data, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk(fin_blk == 0 && fin_pg == 0, "no_finish_after_reset", {fin_pg, fin_blk}, 0);

        run_drain(2, 1'b0, 0, 0);
        run_drain(2, 1'b0, 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
